// File: rtl/seq_alu.sv
// Sequential integer ALU: single-cycle base/address ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
package params_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int OPCODE_WIDTH = 7;
  localparam logic [OPCODE_WIDTH-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_IMM   = 7'b0010011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC = 7'b0010111;
endpackage

module seq_alu #(
  parameter int DATA_WIDTH   = params_pkg::DATA_WIDTH,
  parameter int OPCODE_WIDTH = params_pkg::OPCODE_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [2:0]              funct3_i,
  input  logic [6:0]              funct7_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_WIDTH-1:0]   result_o,
  output logic                    is_zero_o,
  output logic                    is_less_o,
  output logic                    is_less_u_o
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [OPCODE_WIDTH-1:0] OPC_R     = OPCODE_WIDTH'(params_pkg::OPC_R);
  localparam logic [OPCODE_WIDTH-1:0] OPC_IMM   = OPCODE_WIDTH'(params_pkg::OPC_IMM);
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(params_pkg::OPC_LOAD);
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(params_pkg::OPC_STORE);
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL   = OPCODE_WIDTH'(params_pkg::OPC_JAL);
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC = OPCODE_WIDTH'(params_pkg::OPC_AUIPC);

  localparam logic [6:0]     F7_BASE   = 7'b0000000;
  localparam logic [6:0]     F7_ALT    = 7'b0100000;
  localparam logic [6:0]     F7_MULDIV = 7'b0000001;
  localparam logic [W-1:0]   MIN_VAL   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   ONES      = {W{1'b1}};
  localparam logic [SHW-1:0] CNT_LAST  = SHW'(W - 1);

  // busy is state bit 1 and done is state bit 0, so both come straight off flops
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [SHW-1:0]   cnt_r;
  logic [2*W-1:0]   work_r;
  logic [W-1:0]     opnd_r;
  logic             is_div_r;
  logic             neg_r;
  logic [2:0]       f3_r;
  logic [W-1:0]     result_r;

  logic [SHW-1:0]   shamt_s;
  logic [W-1:0]     sra_s;
  logic [W-1:0]     single_res_s;
  logic             calc_go_s;
  logic             div_signed_s;
  logic             a_signed_s;
  logic             b_signed_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [W-1:0]     a_mag_s;
  logic [W-1:0]     b_mag_s;
  logic             neg_s;
  logic [W:0]       mul_sum_s;
  logic [2*W-1:0]   mul_next_s;
  logic [W:0]       div_trial_s;
  logic [2*W-1:0]   div_next_s;
  logic [2*W-1:0]   step_s;
  logic [2*W-1:0]   prod_s;
  logic [W-1:0]     quot_s;
  logic [W-1:0]     rem_s;
  logic [W-1:0]     calc_res_s;

  function automatic logic [W-1:0] base_op(input logic [2:0] f3,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [SHW-1:0] sh;
    logic [W-1:0]   r;
    sh = b[SHW-1:0];
    case (f3)
      3'd0:    r = a + b;
      3'd1:    r = a << sh;
      3'd2:    r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd3:    r = {{(W-1){1'b0}}, (a < b)};
      3'd4:    r = a ^ b;
      3'd5:    r = a >> sh;
      3'd6:    r = a | b;
      3'd7:    r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign shamt_s      = b_i[SHW-1:0];
  assign sra_s        = $unsigned($signed(a_i) >>> shamt_s);
  assign div_signed_s = funct3_i[2] & ~funct3_i[0];

  assign is_zero_o   = (a_i == b_i);
  assign is_less_o   = ($signed(a_i) < $signed(b_i));
  assign is_less_u_o = (a_i < b_i);

  // Instruction decode: single-cycle result, or hand-off to the iterative unit
  always_comb begin
    single_res_s = '0;
    calc_go_s    = 1'b0;
    case (opcode_i)
      OPC_R: begin
        if (funct7_i == F7_BASE) begin
          single_res_s = base_op(funct3_i, a_i, b_i);
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            3'd0:    single_res_s = a_i - b_i;
            3'd5:    single_res_s = sra_s;
            default: single_res_s = '0;
          endcase
        end else if (funct7_i == F7_MULDIV) begin
          // Divide-by-zero and signed overflow bypass the iteration
          if (funct3_i[2] && (b_i == '0)) begin
            single_res_s = funct3_i[1] ? a_i : ONES;
          end else if (div_signed_s && (a_i == MIN_VAL) && (b_i == ONES)) begin
            single_res_s = funct3_i[1] ? '0 : a_i;
          end else begin
            calc_go_s = 1'b1;
          end
        end else begin
          single_res_s = '0;
        end
      end
      OPC_IMM: begin
        case (funct3_i)
          3'd1:    single_res_s = (funct7_i == F7_BASE) ? (a_i << shamt_s) : '0;
          3'd5: begin
            if (funct7_i == F7_BASE) begin
              single_res_s = a_i >> shamt_s;
            end else if (funct7_i == F7_ALT) begin
              single_res_s = sra_s;
            end else begin
              single_res_s = '0;
            end
          end
          default: single_res_s = base_op(funct3_i, a_i, b_i);
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_AUIPC: single_res_s = a_i + b_i;
      default: single_res_s = '0;
    endcase
  end

  // Operand signedness per M op, magnitudes and final result sign
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (funct3_i)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'd2: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    a_neg_s = a_signed_s & a_i[W-1];
    b_neg_s = b_signed_s & b_i[W-1];
    a_mag_s = a_neg_s ? (W'(0) - a_i) : a_i;
    b_mag_s = b_neg_s ? (W'(0) - b_i) : b_i;
    neg_s   = (funct3_i == 3'd6) ? a_neg_s : (a_neg_s ^ b_neg_s);
  end

  // One iteration step; work_r holds {partial/remainder, multiplier/quotient}
  always_comb begin
    mul_sum_s   = {1'b0, work_r[2*W-1:W]} + (work_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    mul_next_s  = {mul_sum_s, work_r[W-1:1]};
    div_trial_s = {work_r[2*W-1:W], work_r[W-1]} - {1'b0, opnd_r};
    if (div_trial_s[W] == 1'b0) begin
      div_next_s = {div_trial_s[W-1:0], work_r[W-2:0], 1'b1};
    end else begin
      div_next_s = {work_r[2*W-2:0], 1'b0};
    end
    step_s = is_div_r ? div_next_s : mul_next_s;
  end

  // Sign correction and selection of the final iterative result
  always_comb begin
    prod_s = neg_r ? ((2*W)'(0) - step_s) : step_s;
    quot_s = neg_r ? (W'(0) - step_s[W-1:0]) : step_s[W-1:0];
    rem_s  = neg_r ? (W'(0) - step_s[2*W-1:W]) : step_s[2*W-1:W];
    case (f3_r)
      3'd0:             calc_res_s = prod_s[W-1:0];
      3'd1, 3'd2, 3'd3: calc_res_s = prod_s[2*W-1:W];
      3'd4, 3'd5:       calc_res_s = quot_s;
      3'd6, 3'd7:       calc_res_s = rem_s;
      default:          calc_res_s = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = calc_go_s ? CALC : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r    <= '0;
      work_r   <= '0;
      opnd_r   <= '0;
      is_div_r <= 1'b0;
      neg_r    <= 1'b0;
      f3_r     <= 3'd0;
      result_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            cnt_r <= '0;
            if (calc_go_s) begin
              work_r   <= {{W{1'b0}}, a_mag_s};
              opnd_r   <= b_mag_s;
              is_div_r <= funct3_i[2];
              neg_r    <= neg_s;
              f3_r     <= funct3_i;
            end else begin
              result_r <= single_res_s;
            end
          end
        end
        CALC: begin
          work_r <= step_s;
          if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            result_r <= calc_res_s;
          end else begin
            cnt_r <= cnt_r + SHW'(1);
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy_o   = state_r[1];
  assign done_o   = state_r[0];
  assign result_o = result_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table plus scoreboard-checked
// multi-cycle sequences (busy profile, held start, reset mid-operation).
module tb_seq_alu;
  localparam logic [6:0] R = 7'h33, IMM = 7'h13, LD = 7'h03, ST = 7'h23;
  localparam logic [6:0] JAL = 7'h6F, AUI = 7'h17, BAD = 7'h7F;
  localparam logic [6:0] F0 = 7'h00, FA = 7'h20, FM = 7'h01;
  localparam logic [31:0] MINV = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic        is_zero_o, is_less_o, is_less_u_o;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    int          start_cyc;
    string       name;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];
  sb_t  mon_e;

  seq_alu dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .opcode_i(opcode_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .is_zero_o(is_zero_o), .is_less_o(is_less_o), .is_less_u_o(is_less_u_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every done_o must match the oldest pending request
  always @(negedge clk) begin
    if (rst_ni === 1'b1 && done_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done_o with no pending request at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result_o, mon_e.exp);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
      end
    end
  end

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, p;
    logic [63:0] ua, ub, up;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb64; r = p[31:0]; end
      3'd1: begin p = sa * sb64; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == MINV && b == 32'hFFFFFFFF) r = a;
        else begin p = sa / sb64; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == MINV && b == 32'hFFFFFFFF) r = 32'd0;
        else begin p = sa % sb64; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0)) return 1;
    if (f3[2] && !f3[0] && a == MINV && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  task automatic addv(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got no done_o in 60 cycles, expected one", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle
  task automatic drive(input vec_t v, input string name);
    opcode_i = v.opc; funct3_i = v.f3; funct7_i = v.f7; a_i = v.a; b_i = v.b;
    start_i = 1'b1;
    sb.push_back('{v.exp, v.lat, cyc, name});
    #1;
    chk({name, "_zero"}, 32'(is_zero_o), 32'(v.a == v.b));
    chk({name, "_lt"}, 32'(is_less_o), 32'($signed(v.a) < $signed(v.b)));
    chk({name, "_ltu"}, 32'(is_less_u_o), 32'(v.a < v.b));
    @(negedge clk);
    start_i = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    vec_t v;
    int bad;
    int dn;
    int k;
    rst_ni = 1'b0; start_i = 1'b0; opcode_i = R; funct3_i = 3'd0; funct7_i = F0;
    a_i = 32'd3; b_i = 32'd4;

    addv(R,   3'd0, F0, 32'd3,        32'd4,        32'd7,        1);
    addv(R,   3'd0, FA, 32'd5,        32'd7,        32'hFFFFFFFE, 1);
    addv(R,   3'd1, F0, 32'd1,        32'h21,       32'd2,        1);
    addv(R,   3'd2, F0, 32'hFFFFFFFF, 32'd1,        32'd1,        1);
    addv(R,   3'd3, F0, 32'hFFFFFFFF, 32'd1,        32'd0,        1);
    addv(R,   3'd4, F0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1);
    addv(R,   3'd5, F0, 32'h80000000, 32'd4,        32'h08000000, 1);
    addv(R,   3'd5, FA, 32'h80000000, 32'h24,       32'hF8000000, 1);
    addv(R,   3'd6, F0, 32'hA,        32'h5,        32'hF,        1);
    addv(R,   3'd7, F0, 32'hC,        32'hA,        32'h8,        1);
    addv(IMM, 3'd0, F0, 32'd10,       32'hFFFFFFFF, 32'd9,        1);
    addv(IMM, 3'd5, FA, 32'hFFFFFF00, 32'd4,        32'hFFFFFFF0, 1);
    addv(LD,  3'd2, F0, 32'h1000,     32'h20,       32'h1020,     1);
    addv(ST,  3'd0, F0, 32'h2000,     32'hFFFFFFFC, 32'h1FFC,     1);
    addv(JAL, 3'd0, F0, 32'h400,      32'h8,        32'h408,      1);
    addv(AUI, 3'd0, F0, 32'h1000,     32'h5000,     32'h6000,     1);
    addv(BAD, 3'd0, F0, 32'h11,       32'h22,       32'd0,        1);
    addv(R,   3'd0, 7'h7F, 32'h11,    32'h22,       32'd0,        1);
    addv(R,   3'd3, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    addv(R,   3'd1, FM, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    addv(R,   3'd2, FM, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    addv(R,   3'd0, FM, MINV,         MINV,         32'd0,        33);
    addv(R,   3'd1, FM, MINV,         MINV,         32'h40000000, 33);
    addv(R,   3'd4, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    addv(R,   3'd6, FM, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    addv(R,   3'd4, FM, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    addv(R,   3'd6, FM, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
    addv(R,   3'd5, FM, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 33);
    addv(R,   3'd7, FM, 32'd100,      32'd7,        32'd2,        33);
    addv(R,   3'd5, FM, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    addv(R,   3'd7, FM, 32'd5,        32'd0,        32'd5,        1);
    addv(R,   3'd4, FM, MINV,         32'hFFFFFFFF, MINV,         1);
    addv(R,   3'd6, FM, MINV,         32'hFFFFFFFF, 32'd0,        1);

    // Reset state, with a start request that must be ignored while held in reset
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    @(negedge clk);
    start_i = 1'b0;

    // Release and start on the same cycle: first edge out of reset must accept
    rst_ni = 1'b1;
    for (int i = 0; i < vt.size(); i++) drive(vt[i], $sformatf("v%0d", i));

    // MUL 7 * -3: busy for cycles 1..33, done at cycle 33
    opcode_i = R; funct3_i = 3'd0; funct7_i = FM; a_i = 32'd7; b_i = 32'hFFFFFFFD;
    start_i = 1'b1;
    sb.push_back('{32'hFFFFFFEB, 33, cyc, "mul_seq"});
    bad = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (busy_o !== (c <= 33)) bad++;
    end
    chk("mul_busy_profile", 32'(bad), 32'd0);
    wait_drain("mul_seq");

    // DIV 100/7 with start held high; operands changed while busy must not be captured
    opcode_i = R; funct3_i = 3'd4; funct7_i = FM; a_i = 32'd100; b_i = 32'd7;
    start_i = 1'b1;
    sb.push_back('{32'd14, 33, cyc, "held_div"});
    @(negedge clk);
    a_i = 32'h0000DEAD; b_i = 32'hFFFFFFFF;
    #1;
    chk("busy_flag_lt", 32'(is_less_o), 32'd0);
    chk("busy_flag_ltu", 32'(is_less_u_o), 32'd1);
    k = 0;
    while (done_o !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("held_div_done_seen", 32'(done_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o === 1'b1) dn++;
    end
    chk("held_div_extra_done", 32'(dn), 32'd0);
    if (sb.size() != 0) sb.delete();

    // Reset pulse 10 cycles into a MUL, then ADD 3+4 right after release
    opcode_i = R; funct3_i = 3'd0; funct7_i = FM; a_i = 32'd9; b_i = 32'd9;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    v.opc = R; v.f3 = 3'd0; v.f7 = F0; v.a = 32'd3; v.b = 32'd4; v.exp = 32'd7; v.lat = 1;
    drive(v, "post_rst_add");

    // Randomised M ops against a 64-bit arithmetic model
    for (int i = 0; i < 24; i++) begin
      int sel;
      v.opc = R; v.f7 = FM;
      v.f3 = 3'($urandom_range(0, 7));
      v.a = $urandom;
      sel = $urandom_range(0, 4);
      case (sel)
        0: v.b = 32'd0;
        1: v.b = 32'($urandom_range(1, 15));
        2: begin v.b = 32'hFFFFFFFF; if (i % 2 == 0) v.a = MINV; end
        default: v.b = $urandom;
      endcase
      v.exp = ref_m(v.f3, v.a, v.b);
      v.lat = ref_lat(v.f3, v.a, v.b);
      drive(v, $sformatf("rnd%0d_f%0d", i, v.f3));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
